pc_stack_ctr: RTL and testbench
===============================

# pc_stack_ctr

Parametrised program counter with conditional/unconditional jumps and a hardware call/return stack. It sits in the fetch stage of the datapath, driving the instruction-memory address. It supersedes the fixed 2-bit counter with a configurable width, a stall input, and subroutine support.

## Interface
Parameters:
- PC_W, 8, counter/address width in bits (≥2)
- DEPTH, 4, return-stack entries (power of two, ≥2)
- RESET_PC, 0, value loaded into pc on reset

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- en  in  1  advance enable; 0 = stall, all state holds
- inc  in  1  increment request
- jnp  in  1  conditional jump request, taken when r2 = 0
- r2  in  1  condition flag (1 = positive)
- jmp  in  1  unconditional jump request
- call  in  1  push return address, jump to target
- ret  in  1  pop return address into pc
- target  in  PC_W  jump/call destination
- pc  out  PC_W  current program counter
- sp_empty  out  1  return stack holds 0 entries
- sp_full  out  1  return stack holds DEPTH entries
- err  out  1  sticky stack fault (PC_TRAP_EN only, else constant 0)

## Operation
- Registered state: pc, DEPTH×PC_W stack array, write pointer wp (log2 DEPTH bits), occupancy cnt (0..DEPTH), err.
- en = 0: nothing changes, regardless of other inputs.
- en = 1, one command per cycle, fixed priority: ret > call > jmp > jnp-taken (jnp & ~r2) > inc > hold.
  - ret, cnt > 0: pc ← stack[wp−1]; wp−1; cnt−1.
  - call, cnt < DEPTH: stack[wp] ← pc+1 (mod 2^PC_W); wp+1; cnt+1; pc ← target.
  - jmp or jnp-taken: pc ← target.
  - jnp with r2 = 1 falls through to inc if inc = 1, else hold.
  - inc: pc ← pc+1, wrapping 2^PC_W−1 → 0.
  - No command: pc holds.
- Pointer arithmetic is modulo DEPTH; pc arithmetic is modulo 2^PC_W.
- sp_empty = (cnt == 0), sp_full = (cnt == DEPTH); both combinational from registered cnt.
- Stack faults (call with cnt = DEPTH, ret with cnt = 0) are defined under Configuration.

## Timing
- All updates on rising clk; new pc visible the cycle after the command is sampled (1-cycle latency).
- A ret sampled in the cycle immediately after a call returns the address that call pushed.
- Reset (async assert, any time incl. mid-call/ret): pc = RESET_PC, wp = 0, cnt = 0, sp_empty = 1, sp_full = 0, err = 0. Stack array contents are not reset and are never read while cnt = 0.
- Release of rst_n is synchronous to clk; first command is sampled on the first rising edge with rst_n = 1.

## Configuration
- Macro PC_TRAP_EN.
- Defined: call when full or ret when empty sets err = 1 on that edge; pc, wp, cnt unchanged that cycle. While err = 1 the block ignores all commands (pc frozen) until rst_n asserts.
- Undefined: call when full still writes stack[wp], advances wp, cnt stays DEPTH (oldest entry overwritten), pc ← target. ret when empty behaves as inc (pc ← pc+1), stack unchanged. err tied to 0.

## Test plan
- Reset/inc: RESET_PC = 0, PC_W = 8; assert rst_n low mid-cycle → pc = 0 immediately; release, inc = 1 for 300 cycles → pc wraps 255 → 0 and ends at 44.
- Conditional jump: pc = 5, target = 8'h3C, jnp = 1, inc = 1: r2 = 1 → pc = 6; r2 = 0 → pc = 8'h3C next cycle.
- Stall/priority: en = 0 with jmp = 1 → pc unchanged; en = 1, ret and call both set with cnt = 1 → ret wins, pc = popped value, cnt = 0.
- Nested call/ret: from pc = 10 call 20, from 20 call 40, ret, ret → pc sequence 20, 40, 21, 11; sp_empty = 1 at end.
- Overflow without PC_TRAP_EN: DEPTH = 4, 5 nested calls then 5 rets → first 4 rets return the most recent 4 return addresses, 5th ret increments pc; err = 0 throughout.
- Fault with PC_TRAP_EN: ret at cnt = 0 → err = 1 next edge, pc frozen under inc/jmp for 10 cycles; rst_n pulse → err = 0, pc = RESET_PC.

Source files
------------

// File: rtl/pc_stack_ctr.sv
// Fetch-stage program counter with jumps and a hardware call/return stack.
// Optional macro PC_TRAP_EN: stack over/underflow latches err and freezes pc.
module pc_stack_ctr #(
    parameter int              PC_W     = 8,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            inc,
    input  logic            jnp,
    input  logic            r2,
    input  logic            jmp,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            sp_empty,
    output logic            sp_full,
    output logic            err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_RET  = 2'd0,
        S_CALL = 2'd1,
        S_JMP  = 2'd2,
        S_INC  = 2'd3
    } sel_e;

    logic [PC_W-1:0] stack [DEPTH];
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_n;
    logic [PC_W-1:0] pc_inc;
    logic [AW-1:0]   wp;
    logic [AW-1:0]   wp_n;
    logic [AW-1:0]   wp_dec;
    logic [AW:0]     cnt;
    logic [AW:0]     cnt_n;
    logic [3:0]      sel;
    logic            push;
    logic            active;
    logic            empty;
    logic            full;

    assign pc_inc = pc_q + PC_W'(1);
    assign wp_dec = wp - AW'(1);
    assign empty  = (cnt == '0);
    assign full   = (cnt == DEPTH_C);

    // One-hot command after fixed priority; jnp only counts when r2 is clear
    always_comb begin
        sel = '0;
        if (ret) begin
            sel[S_RET] = 1'b1;
        end else if (call) begin
            sel[S_CALL] = 1'b1;
        end else if (jmp || (jnp && !r2)) begin
            sel[S_JMP] = 1'b1;
        end else if (inc) begin
            sel[S_INC] = 1'b1;
        end
    end

`ifdef PC_TRAP_EN
    logic err_q;
    logic trap;

    assign active = en && !err_q;
`else
    assign active = en;
`endif

    always_comb begin
        pc_n  = pc_q;
        wp_n  = wp;
        cnt_n = cnt;
        push  = 1'b0;
`ifdef PC_TRAP_EN
        trap  = 1'b0;
`endif
        if (active) begin
            unique case (1'b1)
                sel[S_RET]: begin
                    if (!empty) begin
                        pc_n  = stack[wp_dec];
                        wp_n  = wp_dec;
                        cnt_n = cnt - (AW+1)'(1);
                    end else begin
`ifdef PC_TRAP_EN
                        trap = 1'b1;
`else
                        pc_n = pc_inc;
`endif
                    end
                end
                sel[S_CALL]: begin
                    if (!full) begin
                        push  = 1'b1;
                        wp_n  = wp + AW'(1);
                        cnt_n = cnt + (AW+1)'(1);
                        pc_n  = target;
                    end else begin
`ifdef PC_TRAP_EN
                        trap = 1'b1;
`else
                        // Ring overwrite: oldest return address is lost
                        push = 1'b1;
                        wp_n = wp + AW'(1);
                        pc_n = target;
`endif
                    end
                end
                sel[S_JMP]: pc_n = target;
                sel[S_INC]: pc_n = pc_inc;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            wp   <= '0;
            cnt  <= '0;
        end else begin
            pc_q <= pc_n;
            wp   <= wp_n;
            cnt  <= cnt_n;
        end
    end

    // Stack storage is not reset; it is never read while cnt is zero
    always_ff @(posedge clk) begin
        if (push) begin
            stack[wp] <= pc_inc;
        end
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (trap) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign pc       = pc_q;
    assign sp_empty = empty;
    assign sp_full  = full;

endmodule

// File: tb/tb_pc_stack_ctr.sv
// Directed, table-driven bench for pc_stack_ctr (PC_W=8, DEPTH=4).
// Checks both builds; fault sequences depend on PC_TRAP_EN.
module tb_pc_stack_ctr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, inc, jnp, r2, jmp, call, ret;
    logic [7:0] target;
    logic [7:0] pc;
    logic       sp_empty, sp_full, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_stack_ctr #(
        .PC_W    (8),
        .DEPTH   (4),
        .RESET_PC(8'h00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .inc     (inc),
        .jnp     (jnp),
        .r2      (r2),
        .jmp     (jmp),
        .call    (call),
        .ret     (ret),
        .target  (target),
        .pc      (pc),
        .sp_empty(sp_empty),
        .sp_full (sp_full),
        .err     (err)
    );

    typedef struct {
        string      nm;
        logic       en, inc, jnp, r2, jmp, call, ret;
        logic [7:0] tgt;
        logic [7:0] pc;
        logic       empty, full;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic e, input logic i,
                       input logic jn, input logic r, input logic jm,
                       input logic c, input logic rt, input logic [7:0] t,
                       input logic [7:0] p, input logic em, input logic fu);
        vec_t v;
        v.nm = nm; v.en = e; v.inc = i; v.jnp = jn; v.r2 = r;
        v.jmp = jm; v.call = c; v.ret = rt; v.tgt = t;
        v.pc = p; v.empty = em; v.full = fu;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic e, input logic i, input logic jn,
                         input logic r, input logic jm, input logic c,
                         input logic rt, input logic [7:0] t);
        en = e; inc = i; jnp = jn; r2 = r;
        jmp = jm; call = c; ret = rt; target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; inc = 1'b0; jnp = 1'b0; r2 = 1'b0;
        jmp = 1'b0; call = 1'b0; ret = 1'b0; target = 8'h00;
    endtask

    task automatic chk_state(input string nm, input int p,
                             input int em, input int fu, input int er);
        chk({nm, ".pc"}, int'(pc), p);
        chk({nm, ".empty"}, int'(sp_empty), em);
        chk({nm, ".full"}, int'(sp_full), fu);
        chk({nm, ".err"}, int'(err), er);
    endtask

    initial begin
        // name            en i jn r2 jm c rt tgt    pc    em fu
        add("jmp5",        1, 0, 0, 0, 1, 0, 0, 8'h05, 8'h05, 1, 0);
        add("jnp_r2_inc",  1, 1, 1, 1, 0, 0, 0, 8'h3C, 8'h06, 1, 0);
        add("jnp_r2_hold", 1, 0, 1, 1, 0, 0, 0, 8'h3C, 8'h06, 1, 0);
        add("jmp5b",       1, 0, 0, 0, 1, 0, 0, 8'h05, 8'h05, 1, 0);
        add("jnp_taken",   1, 1, 1, 0, 0, 0, 0, 8'h3C, 8'h3C, 1, 0);
        add("stall_jmp",   0, 0, 0, 0, 1, 0, 0, 8'h77, 8'h3C, 1, 0);
        add("stall_inc",   0, 1, 0, 0, 0, 0, 0, 8'h77, 8'h3C, 1, 0);
        add("nocmd",       1, 0, 0, 0, 0, 0, 0, 8'h77, 8'h3C, 1, 0);
        add("jmp10",       1, 0, 0, 0, 1, 0, 0, 8'd10, 8'd10, 1, 0);
        add("call20",      1, 0, 0, 0, 0, 1, 0, 8'd20, 8'd20, 0, 0);
        add("call40",      1, 0, 0, 0, 0, 1, 0, 8'd40, 8'd40, 0, 0);
        add("ret21",       1, 0, 0, 0, 0, 0, 1, 8'h00, 8'd21, 0, 0);
        add("ret11",       1, 0, 0, 0, 0, 0, 1, 8'h00, 8'd11, 1, 0);
        add("call80",      1, 0, 0, 0, 0, 1, 0, 8'h80, 8'h80, 0, 0);
        add("ret_over_call",1,0, 0, 0, 0, 1, 1, 8'h99, 8'd12, 1, 0);
        add("stall_ret",   0, 0, 0, 0, 0, 0, 1, 8'h00, 8'd12, 1, 0);
        add("callFF",      1, 0, 0, 0, 0, 1, 0, 8'hFF, 8'hFF, 0, 0);
        add("inc_wrap",    1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add("ret13",       1, 0, 0, 0, 0, 0, 1, 8'h00, 8'd13, 1, 0);
        add("jmp_over_inc",1, 1, 0, 0, 1, 0, 0, 8'h50, 8'h50, 1, 0);
        add("call_over_jmp",1,0, 0, 0, 1, 1, 0, 8'h60, 8'h60, 0, 0);
        add("ret51",       1, 0, 0, 0, 0, 0, 1, 8'h00, 8'h51, 1, 0);

        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 1, 0, 0);

        rst_n = 1'b1;
        repeat (3) drive(1, 1, 0, 0, 0, 0, 0, 8'h00);
        chk("inc3", int'(pc), 3);

        // Asynchronous reset mid-cycle, away from the clock edge
        #3 rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 1, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 1; i <= 300; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 8'h00);
            if (i == 255) chk("inc255", int'(pc), 255);
            if (i == 256) chk("inc_wrap0", int'(pc), 0);
        end
        chk("inc300", int'(pc), 44);

        foreach (tbl[k]) begin
            drive(tbl[k].en, tbl[k].inc, tbl[k].jnp, tbl[k].r2,
                  tbl[k].jmp, tbl[k].call, tbl[k].ret, tbl[k].tgt);
            chk_state(tbl[k].nm, int'(tbl[k].pc), int'(tbl[k].empty),
                      int'(tbl[k].full), 0);
        end

        // Stack overflow: four calls fill, fifth hits full
        drive(1, 0, 0, 0, 1, 0, 0, 8'd100);
        drive(1, 0, 0, 0, 0, 1, 0, 8'd110);
        drive(1, 0, 0, 0, 0, 1, 0, 8'd120);
        drive(1, 0, 0, 0, 0, 1, 0, 8'd130);
        drive(1, 0, 0, 0, 0, 1, 0, 8'd140);
        chk_state("full4", 140, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 8'd150);
`ifdef PC_TRAP_EN
        chk_state("ovf_trap", 140, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, (i % 2) == 1, 0, 1, 8'h33);
        end
        chk_state("ovf_frozen", 140, 0, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_state("ovf_rst", 0, 1, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Underflow trap, then pc held for 10 cycles of inc/jmp
        repeat (3) drive(1, 1, 0, 0, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 0, 0, 1, 8'h00);
        chk_state("unf_trap", 3, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 0, (i % 2) == 1, 0, 0, 8'hA5);
        end
        chk_state("unf_frozen", 3, 1, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_state("unf_rst", 0, 1, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 8'h00);
        chk_state("after_trap", 1, 1, 0, 0);
`else
        chk_state("ovf_call", 150, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 8'h00);
        chk_state("ovf_ret1", 141, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 8'h00);
        chk_state("ovf_ret2", 131, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 8'h00);
        chk_state("ovf_ret3", 121, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 8'h00);
        chk_state("ovf_ret4", 111, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 8'h00);
        chk_state("ret_empty_inc", 112, 1, 0, 0);

        // Reset while stack holds entries clears occupancy
        drive(1, 0, 0, 0, 0, 1, 0, 8'd200);
        drive(1, 0, 0, 0, 0, 1, 0, 8'd210);
        #2 rst_n = 1'b0;
        #1;
        chk_state("rst_midstack", 0, 1, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 1, 8'h00);
        chk_state("ret_after_rst", 1, 1, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
